// File: rtl/pc_redirect_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pc_redirect_ctrl_pkg : core width macro, redirect source and FSM encodings -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef size_X_LEN
`define size_X_LEN 32
`endif

package pc_redirect_ctrl_pkg;

  localparam int X_LEN = `size_X_LEN;

  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_BOOT   = 3'd1,
    SRC_BRANCH = 3'd2,
    SRC_IRQ    = 3'd3,
    SRC_MRET   = 3'd4
  } redirect_src_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_redirect_ctrl_prio_mux.sv
// ----------------------------------------------------------------------------
// redirect_prio_mux : one-hot-by-priority select of redirect pc/src/irq_prep -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module redirect_prio_mux
  import pc_redirect_ctrl_pkg::*;
(
  input  logic                  boot_req_i,
  input  logic                  run_req_i,
  input  logic                  mret_i,
  input  logic                  irq_take_i,
  input  logic                  jump_i,
  input  logic                  branch_i,
  input  logic [`size_X_LEN-1:0] initial_pc_i,
  input  logic [`size_X_LEN-1:0] mepc_i,
  input  logic [`size_X_LEN-1:0] irq_vector_i,
  input  logic [`size_X_LEN-1:0] target_i,
  output logic                  valid_o,
  output redirect_src_e         src_o,
  output logic [`size_X_LEN-1:0] pc_o,
  output logic                  irq_prep_o
);

  always_comb begin
    valid_o    = 1'b0;
    src_o      = SRC_NONE;
    pc_o       = '0;
    irq_prep_o = 1'b0;
    if (boot_req_i) begin
      valid_o = 1'b1;
      src_o   = SRC_BOOT;
      pc_o    = initial_pc_i;
    end else if (run_req_i) begin
      // Lower-priority sources losing arbitration are simply dropped.
      if (mret_i) begin
        valid_o = 1'b1;
        src_o   = SRC_MRET;
        pc_o    = mepc_i;
      end else if (irq_take_i) begin
        valid_o    = 1'b1;
        src_o      = SRC_IRQ;
        pc_o       = irq_vector_i;
        irq_prep_o = 1'b1;
      end else if (jump_i || branch_i) begin
        valid_o = 1'b1;
        src_o   = SRC_BRANCH;
        pc_o    = target_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// pc_redirect_ctrl : boot/branch/irq/mret PC redirect FSM with fetch flush -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int debug_param  = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_design_i,
  input  logic                  if_ready_i,
  input  logic [`size_X_LEN-1:0] pc_i,
  input  logic [`size_X_LEN-1:0] initial_pc_i,
  input  logic                  jump_i,
  input  logic                  branch_i,
  input  logic [`size_X_LEN-1:0] target_i,
  input  logic                  mret_i,
  input  logic [`size_X_LEN-1:0] mepc_i,
  input  logic                  irq_req_i,
  input  logic                  irq_en_i,
  input  logic [`size_X_LEN-1:0] irq_vector_i,
  output logic                  redirect_valid_o,
  output logic [`size_X_LEN-1:0] redirect_pc_o,
  output logic [2:0]            redirect_src_o,
  output logic                  irq_prep_o,
  output logic [`size_X_LEN-1:0] mepc_save_o,
  output logic                  flush_o,
  output logic                  pc_advance_o,
  output logic                  in_irq_o
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          in_irq_q, in_irq_d;

  logic          active;
  logic          mux_valid;
  redirect_src_e mux_src;
  logic [`size_X_LEN-1:0] mux_pc;
  logic          mux_irq_prep;

  // Outputs are forced quiet both while disabled and during the reset cycle.
  assign active = enable_design_i && !reset_i;

  redirect_prio_mux u_prio_mux (
    .boot_req_i   (active && (state_q == ST_BOOT)),
    .run_req_i    (active && (state_q == ST_RUN)),
    .mret_i       (mret_i),
    .irq_take_i   (irq_req_i && irq_en_i && !in_irq_q),
    .jump_i       (jump_i),
    .branch_i     (branch_i),
    .initial_pc_i (initial_pc_i),
    .mepc_i       (mepc_i),
    .irq_vector_i (irq_vector_i),
    .target_i     (target_i),
    .valid_o      (mux_valid),
    .src_o        (mux_src),
    .pc_o         (mux_pc),
    .irq_prep_o   (mux_irq_prep)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_irq_d = in_irq_q;
    if (enable_design_i) begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (mux_valid) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
            if (mux_src == SRC_MRET) in_irq_d = 1'b0;
            if (mux_irq_prep)        in_irq_d = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = 3'(cnt_q - 3'd1);
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_BOOT;
      cnt_q    <= 3'd0;
      in_irq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_irq_q <= in_irq_d;
    end
  end

  assign redirect_valid_o = mux_valid;
  assign redirect_pc_o    = mux_pc;
  assign redirect_src_o   = mux_src;
  assign irq_prep_o       = mux_irq_prep;
  assign mepc_save_o      = mux_irq_prep ? pc_i : '0;
  assign flush_o          = active && (state_q == ST_FLUSH);
  assign pc_advance_o     = active && (state_q == ST_RUN) && if_ready_i && !mux_valid;
  assign in_irq_o         = in_irq_q;

`ifndef SYNTHESIS
  if (debug_param != 0) begin : g_trace
    always_ff @(posedge clk_i) begin
      if (redirect_valid_o) begin
        $info("pc_redirect_ctrl: redirect src=%0d pc=%h", redirect_src_o, redirect_pc_o);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_redirect_ctrl : directed + random check against a behavioural model -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_redirect_ctrl;

  localparam int FC = 2;

  logic        clk;
  logic        rst, en, if_ready, jump, branch, mret, irq_req, irq_en;
  logic [31:0] pc, init_pc, target, mepc, vec;
  logic        redirect_valid_o, irq_prep_o, flush_o, pc_advance_o, in_irq_o;
  logic [31:0] redirect_pc_o, mepc_save_o;
  logic [2:0]  redirect_src_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: boot pending flag, remaining squash slots, handler flag.
  int  m_boot   = 1;
  int  m_squash = 0;
  bit  m_in_irq = 0;
  bit  e_valid, e_prep, e_flush, e_adv;
  int  e_src;
  logic [31:0] e_pc, e_mepc;

  pc_redirect_ctrl #(.FLUSH_CYCLES(FC), .debug_param(0)) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .enable_design_i  (en),
    .if_ready_i       (if_ready),
    .pc_i             (pc),
    .initial_pc_i     (init_pc),
    .jump_i           (jump),
    .branch_i         (branch),
    .target_i         (target),
    .mret_i           (mret),
    .mepc_i           (mepc),
    .irq_req_i        (irq_req),
    .irq_en_i         (irq_en),
    .irq_vector_i     (vec),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_src_o   (redirect_src_o),
    .irq_prep_o       (irq_prep_o),
    .mepc_save_o      (mepc_save_o),
    .flush_o          (flush_o),
    .pc_advance_o     (pc_advance_o),
    .in_irq_o         (in_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    bit act;
    @(negedge clk);
    act     = en && !rst;
    e_valid = 0; e_prep = 0; e_flush = 0; e_adv = 0;
    e_src   = 0; e_pc = '0; e_mepc = '0;
    if (act) begin
      if (m_boot != 0) begin
        e_valid = 1; e_src = 1; e_pc = init_pc;
      end else if (m_squash > 0) begin
        e_flush = 1;
      end else begin
        if (mret) begin
          e_valid = 1; e_src = 4; e_pc = mepc;
        end else if (irq_req && irq_en && !m_in_irq) begin
          e_valid = 1; e_src = 3; e_pc = vec; e_prep = 1; e_mepc = pc;
        end else if (jump || branch) begin
          e_valid = 1; e_src = 2; e_pc = target;
        end
        e_adv = if_ready && !e_valid;
      end
    end
    chk("redirect_valid", 32'(redirect_valid_o), 32'(e_valid));
    chk("redirect_src",   32'(redirect_src_o),   32'(e_src));
    chk("redirect_pc",    redirect_pc_o,         e_pc);
    chk("irq_prep",       32'(irq_prep_o),       32'(e_prep));
    chk("mepc_save",      mepc_save_o,           e_mepc);
    chk("flush",          32'(flush_o),          32'(e_flush));
    chk("pc_advance",     32'(pc_advance_o),     32'(e_adv));
    chk("in_irq",         32'(in_irq_o),         32'(m_in_irq));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_boot = 1; m_squash = 0; m_in_irq = 0;
    end else if (en) begin
      if (m_boot != 0) m_boot = 0;
      else if (m_squash > 0) m_squash--;
      else if (e_valid) begin
        m_squash = FC;
        if (e_src == 4) m_in_irq = 0;
        else if (e_src == 3) m_in_irq = 1;
      end
    end
    #1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      advance();
    end
  endtask

  initial begin
    rst = 1; en = 1; if_ready = 0; jump = 0; branch = 0; mret = 0;
    irq_req = 0; irq_en = 0;
    pc = 32'h0; init_pc = 32'h0000_1000; target = 32'h0; mepc = 32'h0; vec = 32'h0;

    // Reset: the first edge initialises the flops, then reset outputs are checked.
    advance();
    step(1);
    rst = 0;

    // Boot pulse, then pc_advance follows if_ready.
    sample();
    chk("boot_pc",  redirect_pc_o, 32'h0000_1000);
    chk("boot_src", 32'(redirect_src_o), 32'd1);
    advance();
    if_ready = 1; step(1);
    if_ready = 0; step(1);
    if_ready = 1;

    // Branch redirect; a jump during the flush window is ignored.
    branch = 1; target = 32'h0000_2000;
    sample();
    chk("branch_pc",  redirect_pc_o, 32'h0000_2000);
    chk("branch_src", 32'(redirect_src_o), 32'd2);
    advance();
    branch = 0; jump = 1; target = 32'h0000_3000;
    step(FC);
    jump = 0; step(1);

    // Interrupt entry, deferred re-entry until mret and flush drain.
    irq_req = 1; irq_en = 1; pc = 32'h0000_1010; vec = 32'h0000_0100;
    sample();
    chk("irq_mepc_save", mepc_save_o, 32'h0000_1010);
    chk("irq_pc",        redirect_pc_o, 32'h0000_0100);
    advance();
    step(FC + 2);
    chk("in_irq_held", 32'(in_irq_o), 32'd1);
    mret = 1; mepc = 32'h0000_1010;
    step(1);
    mret = 0;
    step(FC);
    sample();
    chk("irq_retaken_src", 32'(redirect_src_o), 32'd3);
    advance();

    // mret + irq + branch together: only mret wins; irq retaken afterwards.
    step(FC);
    mret = 1; branch = 1; target = 32'h0000_4000; mepc = 32'h0000_1234;
    sample();
    chk("prio_src", 32'(redirect_src_o), 32'd4);
    advance();
    mret = 0; branch = 0;
    step(FC + 1);

    // Enable low for 5 cycles in the middle of a flush.
    irq_req = 0;
    en = 0; step(5);
    en = 1; step(FC + 1);

    // Reset during flush with the handler active.
    branch = 1; target = 32'h0000_5000;
    step(1);
    branch = 0;
    step(1);
    rst = 1; step(1);
    rst = 0;
    sample();
    chk("post_reset_in_irq", 32'(in_irq_o), 32'd0);
    chk("post_reset_src",    32'(redirect_src_o), 32'd1);
    advance();

    // Randomised phase.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      en       = ($urandom_range(0, 99) < 88);
      if_ready = ($urandom_range(0, 99) < 70);
      mret     = ($urandom_range(0, 99) < 10);
      jump     = ($urandom_range(0, 99) < 12);
      branch   = ($urandom_range(0, 99) < 12);
      irq_en   = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 20) irq_req = ~irq_req;
      pc     = $urandom;
      target = $urandom;
      mepc   = $urandom;
      vec    = $urandom;
      if ($urandom_range(0, 99) < 5) init_pc = $urandom;
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
